miss_repair_engine: RTL and testbench
=====================================

Name: miss_repair_engine

Overview:
- Sits directly downstream of the L1 miss status history register (MSHR).
- Takes one repair request at a time and fetches the missing block from memory over a narrow beat-based bus.
- For store misses, merges the store word into the fetched block. Writes the block into the data cache as a repair (dirty for stores).
- Captures any dirty victim the cache evicts, writes it back to memory, then signals repair completion to the MSHR.

Parameters:
BLOCK_SIZE, 128, cache block width in bits
ADDR_W, 32, address width
BUS_W, 32, memory bus data width; BEATS = BLOCK_SIZE/BUS_W (4 by default)
ROB_IDX_W, 6, ROB index width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
repair_req_i  in  1  MSHR has a repair pending
repair_req_addr_i  in  ADDR_W  miss address
repair_req_data_i  in  32  store data (valid when repair_is_store_i)
repair_req_rob_idx_i  in  ROB_IDX_W  ROB index of the miss
repair_is_store_i  in  1  miss is a store
repair_ack_o  out  1  one-cycle pulse: request accepted
repair_complete_o  out  1  one-cycle pulse: repair done
repair_complete_rob_idx_o  out  ROB_IDX_W  ROB index of the completed repair
cache_wr_en_o  out  1  cache fill write strobe
cache_is_repair_o  out  1  high with cache_wr_en_o
cache_is_repair_dirty_o  out  1  fill is dirty (store miss)
cache_wr_addr_o  out  ADDR_W  block-aligned fill address
cache_wr_data_o  out  BLOCK_SIZE  fill data
wb_evicted_en_i  in  1  cache evicted a dirty block
wb_evicted_addr_i  in  ADDR_W  victim block address
wb_evicted_block_i  in  BLOCK_SIZE  victim data
mem_req_vld_o  out  1  memory request valid
mem_req_rdy_i  in  1  memory accepts request
mem_req_we_o  out  1  1 = write beat, 0 = block read
mem_req_addr_o  out  ADDR_W  request address
mem_req_wdata_o  out  BUS_W  write beat data
mem_rsp_vld_i  in  1  read response beat valid
mem_rsp_data_i  in  BUS_W  read response beat

Behaviour:
- Interface: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset state:
  - FSM to IDLE.
  - All outputs 0, including mem_req_vld_o, repair_ack_o, repair_complete_o and cache_wr_en_o.
  - Beat counter, block buffer and writeback buffer cleared.
  - Reset asserted in any state aborts the operation immediately. No completion is issued.
- FSM states: IDLE, RD_REQ, RD_DATA, FILL, EVICT, WB_REQ, DONE.
- IDLE:
  - If repair_req_i, pulse repair_ack_o in that cycle.
  - Latch addr, data, rob_idx and is_store; go to RD_REQ.
  - mem_rsp_vld_i is ignored in IDLE.
- RD_REQ:
  - Drive mem_req_vld_o=1, we=0, addr = block-aligned address (low log2(BLOCK_SIZE/8) bits zeroed).
  - All request fields stay stable until mem_req_rdy_i. On vld&rdy go to RD_DATA with beat count 0.
- RD_DATA:
  - Each mem_rsp_vld_i stores mem_rsp_data_i into buffer slice [beat*BUS_W +: BUS_W]; beat 0 is the least significant.
  - Beats arrive in order, with arbitrary gaps.
  - After beat BEATS-1, go to FILL.
  - Response beats outside RD_DATA are ignored.
- FILL (exactly 1 cycle):
  - Assert cache_wr_en_o, cache_is_repair_o and cache_wr_addr_o (block-aligned).
  - cache_wr_data_o is the buffer, except for stores: the 32-bit word at index addr[log2(BLOCK_SIZE/8)-1:2] is replaced with the store data.
  - cache_is_repair_dirty_o = is_store. Low two address bits are ignored (word-granular merge).
  - Go to EVICT.
- EVICT (exactly 1 cycle; the cache reports a victim in the cycle after the write):
  - If wb_evicted_en_i, capture victim addr and block, set beat=0, go to WB_REQ.
  - Otherwise go to DONE.
  - wb_evicted_en_i in any other state is ignored.
- WB_REQ:
  - Drive vld=1, we=1, addr = victim_addr + 4*beat (for BUS_W=32), wdata = victim[beat*BUS_W +: BUS_W].
  - Advance beat on each vld&rdy. After beat BEATS-1 is accepted, go to DONE.
- DONE (1 cycle):
  - Pulse repair_complete_o with the latched rob_idx; go to IDLE.
  - repair_req_i is not sampled in DONE; the earliest next ack is the cycle after DONE.
- Clean-miss latency, with rdy high and beats back-to-back: ack at T, request handshake at T+1, beats T+2..T+5, FILL T+6, EVICT T+7, DONE T+8.
- The engine holds at most one repair at a time. The MSHR sees backpressure because repair_ack_o stays low.
- mem_req_vld_o is never deasserted before its handshake, except by reset.

Test Plan:
- Load miss at 0x0000_1234, rdy=1, beats 0xA0,0xA1,0xA2,0xA3 -> ack at T; mem read at addr 0x1230; FILL with data {A3,A2,A1,A0}, dirty=0; no writeback; complete pulse at T+8 with rob_idx 5.
- Store miss at 0x1234, data 0xDEADBEEF, same beats -> fill data {A3,A2,DEADBEEF,A0}, cache_is_repair_dirty_o=1.
- Dirty eviction: wb_evicted_en_i=1 in EVICT, victim addr 0x8000, block {D3,D2,D1,D0} -> 4 write beats at 0x8000/4/8/C carrying D0..D3; then complete.
- Backpressure: mem_req_rdy_i low for 3 cycles in RD_REQ and in WB_REQ beat 2 -> vld, addr and wdata held stable; no beat skipped or duplicated; completion delayed by exactly 3 cycles each.
- Reset asserted after 2 response beats -> next cycle all outputs 0 and state IDLE; stray rsp beats ignored; a new request then completes normally with no completion for the aborted one.
- Back-to-back requests with repair_req_i held high -> second ack occurs exactly 1 cycle after the first complete pulse, never in the DONE cycle.

Source files
------------

// File: rtl/miss_repair_engine_if.sv
// miss_repair_engine_if: MSHR, cache-fill, victim and memory-bus signals of the repair engine
interface miss_repair_engine_if #(
  parameter int BLOCK_SIZE = 128,
  parameter int ADDR_W = 32,
  parameter int BUS_W = 32,
  parameter int ROB_IDX_W = 6
);
  logic repair_req;
  logic [ADDR_W-1:0] repair_req_addr;
  logic [31:0] repair_req_data;
  logic [ROB_IDX_W-1:0] repair_req_rob_idx;
  logic repair_is_store;
  logic repair_ack;
  logic repair_complete;
  logic [ROB_IDX_W-1:0] repair_complete_rob_idx;
  logic cache_wr_en;
  logic cache_is_repair;
  logic cache_is_repair_dirty;
  logic [ADDR_W-1:0] cache_wr_addr;
  logic [BLOCK_SIZE-1:0] cache_wr_data;
  logic wb_evicted_en;
  logic [ADDR_W-1:0] wb_evicted_addr;
  logic [BLOCK_SIZE-1:0] wb_evicted_block;
  logic mem_req_vld;
  logic mem_req_rdy;
  logic mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [BUS_W-1:0] mem_req_wdata;
  logic mem_rsp_vld;
  logic [BUS_W-1:0] mem_rsp_data;
  modport master (
    input repair_req, repair_req_addr, repair_req_data, repair_req_rob_idx, repair_is_store,
    output repair_ack, repair_complete, repair_complete_rob_idx,
    output cache_wr_en, cache_is_repair, cache_is_repair_dirty, cache_wr_addr, cache_wr_data,
    input wb_evicted_en, wb_evicted_addr, wb_evicted_block,
    output mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata,
    input mem_req_rdy, mem_rsp_vld, mem_rsp_data
  );
  modport slave (
    output repair_req, repair_req_addr, repair_req_data, repair_req_rob_idx, repair_is_store,
    input repair_ack, repair_complete, repair_complete_rob_idx,
    input cache_wr_en, cache_is_repair, cache_is_repair_dirty, cache_wr_addr, cache_wr_data,
    output wb_evicted_en, wb_evicted_addr, wb_evicted_block,
    input mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_data
  );
endinterface

// File: rtl/miss_repair_engine.sv
// miss_repair_engine: fetches a missed block, merges store data, fills the cache and writes back any dirty victim
module miss_repair_engine #(
  parameter int BLOCK_SIZE = 128,
  parameter int ADDR_W = 32,
  parameter int BUS_W = 32,
  parameter int ROB_IDX_W = 6
) (
  input logic clk_i,
  input logic rst_i,
  miss_repair_engine_if.master m
);
  localparam int BEATS = BLOCK_SIZE / BUS_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OFF = $clog2(BLOCK_SIZE / 8);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, FILL, EVICT, WB_REQ, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q, vaddr_q, blk_addr;
  logic [31:0] data_q;
  logic [ROB_IDX_W-1:0] rob_q;
  logic store_q;
  logic [BW-1:0] beat;
  logic [BLOCK_SIZE-1:0] buf_q, vblk_q, fill_data;
  logic [OFF-3:0] word_idx;
  logic last_beat, rsp, wr_hs;
  assign blk_addr = addr_q & ~ADDR_W'(BLOCK_SIZE / 8 - 1);
  assign word_idx = addr_q[OFF-1:2];
  assign last_beat = beat == BW'(BEATS - 1);
  assign rsp = state == RD_DATA && m.mem_rsp_vld;
  assign wr_hs = state == WB_REQ && m.mem_req_rdy;
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = m.repair_req ? RD_REQ : IDLE;
      RD_REQ:  state_nx = m.mem_req_rdy ? RD_DATA : RD_REQ;
      RD_DATA: state_nx = rsp && last_beat ? FILL : RD_DATA;
      FILL:    state_nx = EVICT;
      EVICT:   state_nx = m.wb_evicted_en ? WB_REQ : DONE;
      WB_REQ:  state_nx = wr_hs && last_beat ? DONE : WB_REQ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
      rob_q <= '0;
      store_q <= 1'b0;
      beat <= '0;
      buf_q <= '0;
      vaddr_q <= '0;
      vblk_q <= '0;
    end else begin
      if (state == IDLE && m.repair_req) begin
        addr_q <= m.repair_req_addr;
        data_q <= m.repair_req_data;
        rob_q <= m.repair_req_rob_idx;
        store_q <= m.repair_is_store;
      end
      if (state == RD_REQ && m.mem_req_rdy) beat <= '0;
      if (rsp) begin
        buf_q[beat*BUS_W +: BUS_W] <= m.mem_rsp_data;
        beat <= beat + 1'b1;
      end
      if (state == EVICT && m.wb_evicted_en) begin
        vaddr_q <= m.wb_evicted_addr;
        vblk_q <= m.wb_evicted_block;
        beat <= '0;
      end
      if (wr_hs) beat <= beat + 1'b1;
    end
  end
  // Ack is gated by reset so a request seen during reset is never acknowledged.
  always_comb begin
    fill_data = buf_q;
    if (store_q) fill_data[word_idx*32 +: 32] = data_q;
    m.repair_ack = state == IDLE && m.repair_req && !rst_i;
    m.repair_complete = state == DONE;
    m.repair_complete_rob_idx = state == DONE ? rob_q : '0;
    m.cache_wr_en = state == FILL;
    m.cache_is_repair = state == FILL;
    m.cache_is_repair_dirty = state == FILL && store_q;
    m.cache_wr_addr = state == FILL ? blk_addr : '0;
    m.cache_wr_data = state == FILL ? fill_data : '0;
    m.mem_req_vld = state == RD_REQ || state == WB_REQ;
    m.mem_req_we = state == WB_REQ;
    m.mem_req_addr = state == RD_REQ ? blk_addr :
                     state == WB_REQ ? vaddr_q + ADDR_W'(beat) * ADDR_W'(BUS_W / 8) : '0;
    m.mem_req_wdata = state == WB_REQ ? vblk_q[beat*BUS_W +: BUS_W] : '0;
  end
endmodule

// File: tb/tb_miss_repair_engine.sv
// tb_miss_repair_engine: scoreboard bench for the repair engine with a word-level reference model
module tb_miss_repair_engine;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  miss_repair_engine_if bus ();
  miss_repair_engine dut (.clk_i(clk), .rst_i(rst), .m(bus));
  typedef struct {logic [31:0] addr; logic [127:0] data; logic dirty;} fill_t;
  fill_t fill_q[$];
  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];
  logic [5:0] cmp_q[$];
  int cyc = 0, n_tests = 0, n_fail = 0, last_cmp = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event with empty scoreboard at cycle %0d", name, cyc);
  endtask
  logic pend = 0, p_we;
  logic [31:0] p_addr, p_wdata, e_rd;
  logic [63:0] e_wr;
  logic [5:0] e_cmp;
  fill_t e_fill;
  always @(negedge clk) begin
    if (pend) begin
      check("hold_vld", bus.mem_req_vld, 1'b1);
      check("hold_we", bus.mem_req_we, p_we);
      check("hold_addr", bus.mem_req_addr, p_addr);
      check("hold_wdata", bus.mem_req_wdata, p_wdata);
    end
    pend = bus.mem_req_vld && !bus.mem_req_rdy && !rst;
    p_we = bus.mem_req_we;
    p_addr = bus.mem_req_addr;
    p_wdata = bus.mem_req_wdata;
    if (bus.mem_req_vld && bus.mem_req_rdy && !rst) begin
      if (bus.mem_req_we) begin
        if (wr_q.size() == 0) unexpected("mem_write");
        else begin
          e_wr = wr_q.pop_front();
          check("wb_addr", bus.mem_req_addr, e_wr[63:32]);
          check("wb_data", bus.mem_req_wdata, e_wr[31:0]);
        end
      end else begin
        if (rd_q.size() == 0) unexpected("mem_read");
        else begin
          e_rd = rd_q.pop_front();
          check("rd_addr", bus.mem_req_addr, e_rd);
        end
      end
    end
    if (bus.cache_wr_en) begin
      if (fill_q.size() == 0) unexpected("fill");
      else begin
        e_fill = fill_q.pop_front();
        check("fill_is_repair", bus.cache_is_repair, 1'b1);
        check("fill_addr", bus.cache_wr_addr, e_fill.addr);
        check("fill_data", bus.cache_wr_data, e_fill.data);
        check("fill_dirty", bus.cache_is_repair_dirty, e_fill.dirty);
      end
    end
    if (bus.repair_complete) begin
      check("ack_in_done", bus.repair_ack, 1'b0);
      if (cmp_q.size() == 0) unexpected("complete");
      else begin
        e_cmp = cmp_q.pop_front();
        check("complete_rob", bus.repair_complete_rob_idx, e_cmp);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] addr, input logic [31:0] data, input logic [5:0] rob,
                     input logic st, input logic [127:0] beats, input logic ev,
                     input logic [31:0] vaddr, input logic [127:0] vblk, input int rd_stall,
                     input int wb_stall, input int gap_max, input logic keep, input logic b2b);
    logic [31:0] w[4];
    int gaps = 0, t_ack = -1, t_cmp = -1, g;
    for (int i = 0; i < 4; i++) w[i] = beats[32*i +: 32];
    if (st) w[(addr % 16) / 4] = data;
    rd_q.push_back(addr - addr % 16);
    fill_q.push_back('{addr - addr % 16, {w[3], w[2], w[1], w[0]}, st});
    if (ev) for (int i = 0; i < 4; i++) wr_q.push_back({vaddr + 32'(4 * i), vblk[32*i +: 32]});
    cmp_q.push_back(rob);
    step();
    bus.repair_req = 1;
    bus.repair_req_addr = addr;
    bus.repair_req_data = data;
    bus.repair_req_rob_idx = rob;
    bus.repair_is_store = st;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.repair_ack) begin
        t_ack = cyc;
        break;
      end
    end
    if (t_ack < 0) begin
      unexpected("ack_timeout");
      bus.repair_req = 0;
      return;
    end
    if (b2b) check("b2b_ack_gap", 128'(t_ack - last_cmp), 128'd1);
    step();
    if (!keep) bus.repair_req = 0;
    bus.mem_req_rdy = 0;
    repeat (rd_stall) begin
      bus.mem_rsp_vld = 1;
      bus.mem_rsp_data = $urandom;
      step();
    end
    bus.mem_rsp_vld = 0;
    bus.mem_req_rdy = 1;
    step();
    bus.mem_req_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(gap_max, 0);
      gaps += g;
      bus.mem_rsp_vld = 0;
      repeat (g) step();
      bus.mem_rsp_vld = 1;
      bus.mem_rsp_data = beats[32*i +: 32];
      step();
    end
    bus.mem_rsp_data = $urandom;
    bus.wb_evicted_en = 1;
    bus.wb_evicted_addr = 32'hFFFF_0000;
    bus.wb_evicted_block = {4{$urandom}};
    step();
    bus.mem_rsp_vld = 0;
    bus.wb_evicted_en = ev;
    bus.wb_evicted_addr = vaddr;
    bus.wb_evicted_block = vblk;
    step();
    bus.wb_evicted_en = 1;
    bus.wb_evicted_addr = 32'hFFFF_0000;
    bus.wb_evicted_block = {4{$urandom}};
    if (ev) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 2) repeat (wb_stall) begin
          bus.mem_req_rdy = 0;
          step();
        end
        bus.mem_req_rdy = 1;
        step();
      end
      bus.mem_req_rdy = 0;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.repair_complete) begin
        t_cmp = cyc;
        break;
      end
    end
    bus.wb_evicted_en = 0;
    if (t_cmp < 0) unexpected("complete_timeout");
    else check("latency", 128'(t_cmp - t_ack), 128'(8 + rd_stall + gaps + (ev ? 4 + wb_stall : 0)));
    last_cmp = t_cmp;
  endtask
  function automatic logic [127:0] outs();
    return {bus.mem_req_vld, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.repair_ack,
            bus.repair_complete, bus.repair_complete_rob_idx, bus.cache_wr_en, bus.cache_is_repair,
            bus.cache_is_repair_dirty, bus.cache_wr_addr, |bus.cache_wr_data};
  endfunction
  localparam logic [127:0] A_BEATS = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] D_BLK = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
  int t0;
  initial begin
    bus.repair_req = 0;
    bus.repair_req_addr = 0;
    bus.repair_req_data = 0;
    bus.repair_req_rob_idx = 0;
    bus.repair_is_store = 0;
    bus.wb_evicted_en = 0;
    bus.wb_evicted_addr = 0;
    bus.wb_evicted_block = 0;
    bus.mem_req_rdy = 0;
    bus.mem_rsp_vld = 0;
    bus.mem_rsp_data = 0;
    repeat (3) step();
    @(negedge clk);
    check("reset_outputs", outs(), 128'd0);
    step();
    rst = 0;
    run(32'h0000_1234, 32'h0, 6'd5, 0, A_BEATS, 0, 0, 0, 0, 0, 0, 0, 0);
    run(32'h0000_1234, 32'hDEAD_BEEF, 6'd6, 1, A_BEATS, 0, 0, 0, 0, 0, 0, 0, 0);
    run(32'h0000_2000, 32'h0, 6'd7, 0, A_BEATS, 1, 32'h8000, D_BLK, 0, 0, 0, 0, 0);
    run(32'h0000_3458, 32'h1111_2222, 6'd8, 1, A_BEATS, 1, 32'h8000, D_BLK, 3, 3, 0, 0, 0);
    // Abort mid-read: only the read request may be observed, no fill and no completion.
    rd_q.push_back(32'h0000_5670);
    step();
    bus.repair_req = 1;
    bus.repair_req_addr = 32'h0000_5678;
    bus.repair_req_rob_idx = 6'd9;
    bus.repair_is_store = 0;
    t0 = 0;
    for (int k = 0; k < 10 && !t0; k++) begin
      @(negedge clk);
      t0 = int'(bus.repair_ack);
    end
    check("abort_ack_seen", t0, 1);
    step();
    bus.repair_req = 0;
    bus.mem_req_rdy = 1;
    step();
    bus.mem_req_rdy = 0;
    repeat (2) begin
      bus.mem_rsp_vld = 1;
      bus.mem_rsp_data = $urandom;
      step();
    end
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("abort_outputs", outs(), 128'd0);
    repeat (4) step();
    bus.mem_rsp_vld = 0;
    @(negedge clk);
    check("abort_idle_outputs", outs(), 128'd0);
    run(32'h0000_9ABC, 32'h5555_AAAA, 6'd10, 1, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, 0, 0, 0, 0, 0, 0, 0);
    run(32'h0000_4000, 32'h0, 6'd11, 0, A_BEATS, 0, 0, 0, 0, 0, 0, 1, 0);
    run(32'h0000_4444, 32'h7777_8888, 6'd12, 1, A_BEATS, 1, 32'hC000, D_BLK, 0, 0, 0, 0, 1);
    for (int i = 0; i < 25; i++)
      run($urandom, $urandom, 6'($urandom), 1'($urandom), {4{$urandom}}, 1'($urandom),
          $urandom & 32'hFFFF_FFF0, {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(3, 0), $urandom_range(3, 0), 2, 0, 0);
    repeat (3) step();
    check("scoreboard_drained", 128'(fill_q.size() + rd_q.size() + wr_q.size() + cmp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
